// File: rtl/vga_stream_out.sv
// vga_stream_out: final pixel stage in front of the VGA DAC pins.
//
// An RGB222 Avalon-ST stream is buffered in a small elastic FIFO. Free-running
// counters generate the video timing (640x480@60 by default). The stream is
// locked to the raster using startofpacket. A short or broken frame is blanked
// and the block re-locks on the next frame, so the sync outputs are never
// disturbed.
//
// Ports:
//   clk, reset_n             pixel clock, asynchronous active-low reset
//   snk_data/valid/sop       pixel sink {R[5:4],G[3:2],B[1:0]}, sop = first pixel
//   snk_ready                FIFO not full
//   clear_status             clears the sticky status flags
//   vga_red/green/blue       registered colour, black outside streamed pixels
//   vga_hs, vga_vs           active-low syncs
//   vga_clk, vga_sync        DAC clock (~clk), sync-on-green (tied low)
//   vga_blank                high during active video (DAC BLANK_n)
//   frame_start              one-cycle pulse, aligned with pixel (0,0) on the pins
//   stat_underflow           sticky: FIFO empty at an active pixel while streaming
//   stat_sof_error           sticky: sop arrived before the frame was complete
module vga_stream_out #(
  parameter int FIFO_DEPTH = 16,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] snk_data,
  input  logic       snk_valid,
  input  logic       snk_sop,
  output logic       snk_ready,
  input  logic       clear_status,
  output logic [1:0] vga_red,
  output logic [1:0] vga_green,
  output logic [1:0] vga_blue,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_clk,
  output logic       vga_sync,
  output logic       vga_blank,
  output logic       frame_start,
  output logic       stat_underflow,
  output logic       stat_sof_error
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra count of range so that the sync-window end always fits.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 4");
  end

  typedef enum logic [1:0] {
    ST_SEEK,    // discarding entries until a sop reaches the FIFO head
    ST_ARMED,   // sop held at the head, waiting for raster origin
    ST_STREAM   // popping one entry per active pixel
  } state_t;

  typedef struct packed {
    logic       sop;
    logic [5:0] data;
  } fifo_entry_t;

  // ---------------------------------------------------------------------------
  // Elastic pixel FIFO. Pointers carry an extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  fifo_entry_t       mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              full, empty, push, pop;
  fifo_entry_t       head;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign snk_ready = ~full;
  assign push      = snk_valid & snk_ready;
  assign head      = mem[rd_ptr_q[AW-1:0]];

  // NOTE: the storage array has no reset; dropping its contents on reset only
  // needs the pointers cleared, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= fifo_entry_t'{sop: snk_sop, data: snk_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Raster position, decoded for the current cycle.
  // ---------------------------------------------------------------------------
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic          active, at_origin, at_end, hs_win, vs_win;

  assign active    = (h_q < H_ACT) && (v_q < V_ACT);
  assign at_origin = (h_q == '0) && (v_q == '0);
  assign at_end    = (h_q == H_LAST) && (v_q == V_LAST);
  assign hs_win    = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_win    = (v_q >= VS_START) && (v_q < VS_END);

  // ---------------------------------------------------------------------------
  // Stream lock: next state, FIFO pop and the pixel value for the next cycle.
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [5:0] pix_d;
  logic       uf_set, sof_set;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    pix_d   = '0;
    uf_set  = 1'b0;
    sof_set = 1'b0;
    unique case (state_q)
      ST_SEEK: begin
        if (!empty) begin
          if (head.sop) state_d = ST_ARMED;
          else          pop     = 1'b1;
        end
      end
      ST_ARMED: begin
        // The held sop entry becomes pixel (0,0).
        if (at_origin && !empty) begin
          state_d = ST_STREAM;
          pop     = 1'b1;
          pix_d   = head.data;
        end
      end
      ST_STREAM: begin
        if (active) begin
          if (empty) begin
            // Show black and keep going; later pixels are not shifted back.
            uf_set = 1'b1;
          end else if (head.sop) begin
            // Next frame arrived early: blank the rest and re-lock on it.
            sof_set = 1'b1;
            state_d = ST_ARMED;
          end else begin
            pop   = 1'b1;
            pix_d = head.data;
          end
        end
        // Leftover pixels of an over-long frame are discarded by SEEK.
        if (at_end) state_d = ST_SEEK;
      end
      default: state_d = ST_SEEK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters, pointers and registered pin outputs.
  // ---------------------------------------------------------------------------
  logic [5:0] rgb_q;
  logic       hs_q, vs_q, blank_q, frame_start_q, underflow_q, sof_error_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_SEEK;
      h_q           <= '0;
      v_q           <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      sof_error_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      rgb_q         <= pix_d;
      hs_q          <= ~hs_win;
      vs_q          <= ~vs_win;
      blank_q       <= active;
      frame_start_q <= at_origin;
      // A new event wins over a clear in the same cycle.
      underflow_q   <= uf_set  | (underflow_q & ~clear_status);
      sof_error_q   <= sof_set | (sof_error_q & ~clear_status);
    end
  end

  assign {vga_red, vga_green, vga_blue} = rgb_q;
  assign vga_hs         = hs_q;
  assign vga_vs         = vs_q;
  assign vga_blank      = blank_q;
  assign frame_start    = frame_start_q;
  assign stat_underflow = underflow_q;
  assign stat_sof_error = sof_error_q;
  assign vga_clk        = ~clk;
  assign vga_sync       = 1'b0;

endmodule

// File: tb/tb_vga_stream_out.sv
// Testbench for vga_stream_out, using a reduced raster (16x11 total) so that
// many whole frames fit in a short run. A queue-based reference model predicts
// every pin one cycle ahead from the raster position and the accepted pixels.
module tb_vga_stream_out;

  localparam int DEPTH = 16;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NPIX  = HA * VA;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] snk_data = '0;
  logic       snk_valid = 1'b0;
  logic       snk_sop = 1'b0;
  logic       clear_status = 1'b0;
  logic       snk_ready;
  logic [1:0] vga_red, vga_green, vga_blue;
  logic       vga_hs, vga_vs, vga_clk, vga_sync, vga_blank;
  logic       frame_start, stat_underflow, stat_sof_error;

  initial forever #20 clk = ~clk;

  vga_stream_out #(
    .FIFO_DEPTH(DEPTH),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .snk_data      (snk_data),
    .snk_valid     (snk_valid),
    .snk_sop       (snk_sop),
    .snk_ready     (snk_ready),
    .clear_status  (clear_status),
    .vga_red       (vga_red),
    .vga_green     (vga_green),
    .vga_blue      (vga_blue),
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs),
    .vga_clk       (vga_clk),
    .vga_sync      (vga_sync),
    .vga_blank     (vga_blank),
    .frame_start   (frame_start),
    .stat_underflow(stat_underflow),
    .stat_sof_error(stat_sof_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: accepted pixels in a queue, raster position as a plain
  // cycle index within the frame, and the lock mode of the display.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       sop;
    logic [5:0] data;
  } ent_t;
  typedef enum {HUNTING, WAITING, SHOWING} mode_t;

  ent_t       q[$];
  mode_t      mode = HUNTING;
  int         pos = 0;
  logic [5:0] e_rgb = '0;
  logic       e_hs = 1'b1, e_vs = 1'b1, e_blank = 1'b0, e_fs = 1'b0;
  logic       e_uf = 1'b0, e_sof = 1'b0;

  int         m_h, m_v;
  bit         m_act, m_rdy, m_uf, m_sof;
  logic [5:0] m_px;
  ent_t       m_e;

  task automatic compare_pins();
    check("rgb",         {vga_red, vga_green, vga_blue}, e_rgb);
    check("hs",          vga_hs,         e_hs);
    check("vs",          vga_vs,         e_vs);
    check("blank",       vga_blank,      e_blank);
    check("frame_start", frame_start,    e_fs);
    check("underflow",   stat_underflow, e_uf);
    check("sof_error",   stat_sof_error, e_sof);
    check("sync",        vga_sync,       0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      mode = HUNTING;
      pos  = 0;
      e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0;
      e_fs = 1'b0; e_uf = 1'b0; e_sof = 1'b0;
      compare_pins();
    end else begin
      compare_pins();
      m_h   = pos % HT;
      m_v   = pos / HT;
      m_act = (m_h < HA) && (m_v < VA);
      m_rdy = q.size() < DEPTH;
      check("snk_ready", snk_ready, m_rdy);
      m_px  = '0;
      m_uf  = 0;
      m_sof = 0;
      case (mode)
        HUNTING: begin
          if (q.size() > 0) begin
            if (q[0].sop) mode = WAITING;
            else          m_e = q.pop_front();
          end
        end
        WAITING: begin
          if (pos == 0 && q.size() > 0) begin
            m_e  = q.pop_front();
            m_px = m_e.data;
            mode = SHOWING;
          end
        end
        default: begin
          if (m_act) begin
            if (q.size() == 0) m_uf = 1;
            else if (q[0].sop) begin
              m_sof = 1;
              mode  = WAITING;
            end else begin
              m_e  = q.pop_front();
              m_px = m_e.data;
            end
          end
          if (pos == FRAME - 1 && mode == SHOWING) mode = HUNTING;
        end
      endcase
      e_rgb   = m_px;
      e_hs    = !(m_h >= HA + HF && m_h < HA + HF + HS);
      e_vs    = !(m_v >= VA + VF && m_v < VA + VF + VS);
      e_blank = m_act;
      e_fs    = (pos == 0);
      e_uf    = m_uf  || (e_uf  && !clear_status);
      e_sof   = m_sof || (e_sof && !clear_status);
      if (snk_valid && m_rdy) begin
        m_e = {snk_sop, snk_data};
        q.push_back(m_e);
      end
      pos = (pos + 1) % FRAME;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change #1 after the rising edge).
  // ---------------------------------------------------------------------------
  task automatic send(input bit sop, input logic [5:0] d);
    int waited;
    bit acc;
    waited = 0;
    acc    = 0;
    snk_valid = 1'b1;
    snk_sop   = sop;
    snk_data  = d;
    while (!acc && waited < 2 * FRAME) begin
      @(negedge clk);
      acc = snk_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    check("push_accepted", acc, 1);
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
  endtask

  task automatic idle(input int n);
    snk_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input bit counting);
    for (int i = 0; i < n; i++) begin
      send(i == 0, counting ? 6'(i % 64) : 6'($urandom));
    end
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    @(posedge clk);
    #1;
    clear_status = 1'b0;
  endtask

  task automatic check_reset_pins(input string tag);
    @(negedge clk);
    check({tag, "_rgb"},   {vga_red, vga_green, vga_blue}, 0);
    check({tag, "_hs"},    vga_hs, 1);
    check({tag, "_vs"},    vga_vs, 1);
    check({tag, "_blank"}, vga_blank, 0);
    check({tag, "_stat"},  {stat_underflow, stat_sof_error}, 0);
  endtask

  initial begin
    // Reset and DAC clock phase.
    #5 reset_n = 1'b0;
    check_reset_pins("rst");
    @(posedge clk);
    #1;
    check("vga_clk_high_phase", vga_clk, 0);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("vga_clk_low_phase", vga_clk, 1);
    check("ready_after_reset", snk_ready, 1);
    @(posedge clk);
    #1;

    // Full frame with a counting pattern; no flags expected.
    send_frame(NPIX, 1);
    idle(FRAME + HT);
    check("frame1_no_underflow", stat_underflow, 0);
    check("frame1_no_sof_error", stat_sof_error, 0);

    // Garbage ahead of a random frame.
    for (int i = 0; i < 5; i++) send(0, 6'($urandom));
    send_frame(NPIX, 0);
    idle(FRAME + HT);
    check("garbage_no_flags", {stat_underflow, stat_sof_error}, 0);

    // Underflow: a long valid gap early in the frame.
    for (int i = 0; i < NPIX; i++) begin
      if (i == 20) idle(50);
      send(i == 0, 6'($urandom));
    end
    idle(FRAME + HT);
    check("underflow_set", stat_underflow, 1);
    check("underflow_no_sof", stat_sof_error, 0);
    pulse_clear();
    @(negedge clk);
    check("underflow_cleared", stat_underflow, 0);
    @(posedge clk);
    #1;

    // Early sop: short frame followed immediately by a full one.
    send_frame(20, 0);
    send_frame(NPIX, 0);
    idle(FRAME + HT);
    check("sof_error_set", stat_sof_error, 1);
    pulse_clear();
    @(negedge clk);
    check("sof_error_cleared", stat_sof_error, 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a streamed frame.
    for (int i = 0; i < 30; i++) send(i == 0, 6'($urandom));
    begin
      int waited;
      waited = 0;
      while (pos / HT != 3 && waited < 3 * FRAME) begin
        @(negedge clk);
        #1;
        waited++;
      end
      check("reached_line_3", pos / HT, 3);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    check_reset_pins("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_frame(NPIX, 0);
    idle(2 * FRAME);
    check("final_no_flags", {stat_underflow, stat_sof_error}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_stream_out.md
Name: vga_stream_out

Overview:
- Final pixel stage ahead of the fpga_vga_* pins of the FPGA_VGA system.
- Accepts an RGB222 pixel stream from the DDR3 framebuffer reader (Avalon-ST sink) into a small elastic FIFO.
- Generates 640x480@60 timing at a 25 MHz pixel clock and drives red/green/blue, hs, vs, clk, sync and blank.
- Aligns the stream to frame start via startofpacket; handles underflow and misaligned frames without losing sync.

Parameters:
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 4.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BP, 33, vertical back porch, in lines.

Ports:
- clk  in  1  pixel clock, 25 MHz.
- reset_n  in  1  asynchronous active-low reset.
- snk_data  in  6  pixel {R[5:4],G[3:2],B[1:0]}.
- snk_valid  in  1  sink valid.
- snk_sop  in  1  first pixel of frame.
- snk_ready  out  1  high when FIFO not full.
- clear_status  in  1  clears sticky flags.
- vga_red  out  2  red.
- vga_green  out  2  green.
- vga_blue  out  2  blue.
- vga_hs  out  1  hsync, active low.
- vga_vs  out  1  vsync, active low.
- vga_clk  out  1  DAC clock, = ~clk.
- vga_sync  out  1  constant 0.
- vga_blank  out  1  high during active video (DAC BLANK_n).
- frame_start  out  1  one-cycle pulse at h=0,v=0.
- stat_underflow  out  1  sticky: FIFO empty at an active pixel while STREAM.
- stat_sof_error  out  1  sticky: sop seen before the frame was complete.

Behaviour:
- Reset values: h_cnt=0, v_cnt=0, FIFO empty, state SEEK; rgb=0, hs=1, vs=1, blank=0, frame_start=0, stat_*=0; snk_ready=1 once reset releases.
- FIFO: write on snk_valid&&snk_ready, storing {sop,data}; snk_ready = !full, registered-free; simultaneous push and pop when full is not allowed (ready already low).
- Counters: h_cnt 0..H_TOTAL-1 (800), wraps and increments v_cnt; v_cnt 0..V_TOTAL-1 (525), wraps to 0. Free-running from reset and independent of stream state.
- Active region: active = h<H_ACTIVE && v<V_ACTIVE.
- Sync windows: hs low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751); vs low for 490 <= v < 492.
- Latency: all pin outputs are registered; a pin value at cycle t+1 reflects the counter and FIFO head at cycle t. frame_start is aligned with the first active pixel on the pins.
- State SEEK: pop one entry per cycle whenever the head has sop=0 (discard). When the head has sop=1, do not pop; go to ARMED.
- State ARMED: hold the head. At h=0,v=0 go to STREAM and pop the head as pixel (0,0).
- State STREAM, at each active pixel other than (0,0):
  - head valid with sop=0: pop and output it.
  - FIFO empty: output black, set stat_underflow, stay in STREAM. The next pixel is not shifted.
  - head has sop=1: do not pop, output black, set stat_sof_error, go to ARMED. The rest of the frame is black.
- Frame end: at h=799,v=524 STREAM goes to SEEK, so any excess pixels of the old frame are discarded before the next sop.
- Blanking output: outside STREAM, and at blanked positions, rgb=0. vga_blank follows active regardless of state.
- Status clearing: clear_status clears both sticky flags next cycle. A set and a clear in the same cycle resolve to set.
- Reset mid-frame: asynchronous return to all reset values; FIFO contents are dropped.

Test Plan:
- Reset: hold reset_n=0 -> rgb=0, hs=vs=1, blank=0, stat=0; after release, first frame_start occurs 1 cycle after the counters hit (0,0).
- Full frame: feed 307200 pixels, first with sop, data = pixel index mod 64 -> pins show the index sequence over the active area; hs low for exactly 96 cycles/line starting at h=656 (+1 latency); vs low for lines 490-491; no status flags set.
- Garbage first: 5 pixels with sop=0, then a frame -> 5 entries discarded, frame displayed correctly from (0,0).
- Underflow: deassert snk_valid for 50 cycles mid line 10 -> black pixels on those positions, stat_underflow=1; clear_status -> 0.
- Early sop: send 1000 pixels then a new sop frame -> pixels 1000+ of frame 1 are black, stat_sof_error=1; the new frame starts at the next (0,0).
- Reset mid-frame at v=200 -> outputs at reset values immediately; after release, SEEK/ARMED resync displays the next sop frame correctly.
